// File: rtl/uart_sdram_pkg.sv
// rtl/uart_sdram_pkg.sv - opcodes, response bytes, error codes and parser states
package uart_sdram_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_OP  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_ISSUE,
    S_WAIT_RD,
    S_SEND_HI,
    S_SEND_LO,
    S_SEND_ACK,
    S_SEND_ERR
  } state_e;

endpackage

// File: rtl/cmd_timeout_ctr.sv
// rtl/cmd_timeout_ctr.sv - reloadable down-counter that flags an expired inter-byte window
module cmd_timeout_ctr #(
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clr restarts the window; while enabled the count runs down and parks at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // zero is reached TIMEOUT_CYC-1 enabled cycles after the last restart
  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART byte-stream command parser issuing single-word SDRAM requests
module uart_cmd_parser
  import uart_sdram_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              err_pulse,
  output logic [1:0]        err_code
);

  // A window shorter than two cycles cannot separate restart from expiry.
  if (TIMEOUT_CYC < 2 || CLK_FREQ <= 0) begin : g_bad_params
  end

  state_e            state_q, state_d;
  logic [23:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              err_pulse_q, err_pulse_d;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;
  logic busy;

  assign tmr_en = (state_q == S_ADDR) || (state_q == S_WDATA) || (state_q == S_WAIT_RD);
  assign busy   = (state_q == S_ISSUE)    || (state_q == S_WAIT_RD) ||
                  (state_q == S_SEND_HI)  || (state_q == S_SEND_LO) ||
                  (state_q == S_SEND_ACK) || (state_q == S_SEND_ERR);

  cmd_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // next-state: packet assembly, request issue, response sequencing and error capture
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    err_code_d  = err_code_q;
    err_pulse_d = 1'b0;
    tmr_clr     = 1'b0;

    // a byte arriving while a request or response is in flight is dropped
    if (rx_valid && busy) begin
      err_code_d  = ERR_OVERRUN;
      err_pulse_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            is_wr_d = (rx_data == OP_WRITE);
            cnt_d   = 2'd0;
            tmr_clr = 1'b1;
            state_d = S_ADDR;
          end else begin
            err_code_d  = ERR_BAD_OP;
            err_pulse_d = 1'b1;
            state_d     = S_SEND_ERR;
          end
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          tmr_clr = 1'b1;
          addr_d  = {addr_q[15:0], rx_data};
          if (cnt_q == 2'd2) begin
            cnt_d   = 2'd0;
            state_d = is_wr_q ? S_WDATA : S_ISSUE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (tmr_expired) begin
          err_code_d  = ERR_TIMEOUT;
          err_pulse_d = 1'b1;
          state_d     = S_SEND_ERR;
        end
      end
      S_WDATA: begin
        if (rx_valid) begin
          tmr_clr = 1'b1;
          wdata_d = {wdata_q[DATA_W-9:0], rx_data};
          if (cnt_q == 2'd1) begin
            cnt_d   = 2'd0;
            state_d = S_ISSUE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (tmr_expired) begin
          err_code_d  = ERR_TIMEOUT;
          err_pulse_d = 1'b1;
          state_d     = S_SEND_ERR;
        end
      end
      S_ISSUE: begin
        if (req_ready) begin
          state_d = is_wr_q ? S_SEND_ACK : S_WAIT_RD;
          tmr_clr = !is_wr_q;
        end
      end
      S_WAIT_RD: begin
        if (rd_valid) begin
          rd_d    = rd_data;
          state_d = S_SEND_HI;
        end else if (tmr_expired) begin
          err_code_d  = ERR_TIMEOUT;
          err_pulse_d = 1'b1;
          state_d     = S_SEND_ERR;
        end
      end
      S_SEND_HI: begin
        if (tx_ready) state_d = S_SEND_LO;
      end
      S_SEND_LO, S_SEND_ACK, S_SEND_ERR: begin
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      err_code_q  <= err_code_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // response byte follows the send state directly so it holds until accepted
  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      S_SEND_HI:  tx_data = rd_q[DATA_W-1 -: 8];
      S_SEND_LO:  tx_data = rd_q[7:0];
      S_SEND_ACK: tx_data = RSP_ACK;
      S_SEND_ERR: tx_data = RSP_ERR;
      default:    tx_data = 8'h00;
    endcase
  end

  assign req_valid = (state_q == S_ISSUE);
  assign req_write = is_wr_q;
  assign req_addr  = addr_q[ADDR_W-1:0];
  assign req_wdata = wdata_q;
  assign tx_valid  = (state_q == S_SEND_HI) || (state_q == S_SEND_LO) ||
                     (state_q == S_SEND_ACK) || (state_q == S_SEND_ERR);
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        err_pulse;
  logic [1:0]  err_code;

  uart_cmd_parser #(
    .CLK_FREQ(50_000_000), .ADDR_W(24), .DATA_W(16), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rd_valid(rd_valid),
    .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .err_pulse(err_pulse), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // packet-level model state
  logic [7:0]  pkt[$];
  int          last_rx_cyc;
  logic        pend_req, req_seen, waiting_rd;
  logic        exp_write;
  logic [23:0] exp_addr;
  logic [15:0] exp_wdata;
  int          exp_req_cyc;
  logic [7:0]  exp_tx[$];
  logic [1:0]  exp_err_code[$];
  int          exp_err_cyc[$];
  logic [1:0]  last_err;
  logic        busy_now;

  // what the DUT actually delivered, for literal pins
  logic [7:0]  tx_log[$];
  logic [23:0] log_addr;
  logic [15:0] log_wdata;
  logic        log_write;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic model_busy();
    return pend_req || waiting_rd || (exp_tx.size() != 0);
  endfunction

  function automatic logic [7:0] tx_back(input int k);
    if (tx_log.size() > k) return tx_log[tx_log.size() - 1 - k];
    return 8'hxx;
  endfunction

  task automatic model_reset();
    pkt.delete();
    exp_tx.delete();
    exp_err_code.delete();
    exp_err_cyc.delete();
    pend_req    = 1'b0;
    req_seen    = 1'b0;
    waiting_rd  = 1'b0;
    last_err    = 2'd0;
    last_rx_cyc = 0;
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_err_code.push_back(code);
    exp_err_cyc.push_back(cyc + 1);
  endtask

  task automatic model_rx(input logic [7:0] b);
    last_rx_cyc = cyc;
    if (pkt.size() == 0 && b != 8'h57 && b != 8'h52) begin
      push_err(2'd1);
      exp_tx.push_back(8'h45);
    end else begin
      pkt.push_back(b);
      if (pkt.size() == ((pkt[0] == 8'h57) ? 6 : 4)) begin
        exp_write = (pkt[0] == 8'h57);
        exp_addr  = {pkt[1], pkt[2], pkt[3]};
        exp_wdata = 16'h0000;
        if (exp_write) exp_wdata = {pkt[4], pkt[5]};
        exp_req_cyc = cyc + 1;
        pend_req    = 1'b1;
        req_seen    = 1'b0;
        pkt.delete();
      end
    end
  endtask

  task automatic compare_req();
    if (req_valid) begin
      if (!pend_req) begin
        check("req_valid_unexpected", 32'(req_valid), 32'd0);
      end else begin
        if (!req_seen) begin
          check("req_start_cycle", 32'(cyc), 32'(exp_req_cyc));
          req_seen = 1'b1;
        end
        check("req_write", 32'(req_write), 32'(exp_write));
        check("req_addr", 32'(req_addr), 32'(exp_addr));
        if (exp_write) check("req_wdata", 32'(req_wdata), 32'(exp_wdata));
        if (req_ready) begin
          log_addr  = req_addr;
          log_wdata = req_wdata;
          log_write = req_write;
          pend_req  = 1'b0;
          if (exp_write) exp_tx.push_back(8'h4B);
          else waiting_rd = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_tx();
    if (tx_valid) begin
      if (exp_tx.size() == 0) begin
        check("tx_valid_unexpected", 32'(tx_valid), 32'd0);
      end else begin
        check("tx_data", 32'(tx_data), 32'(exp_tx[0]));
        if (tx_ready) begin
          tx_log.push_back(tx_data);
          void'(exp_tx.pop_front());
        end
      end
    end
  endtask

  task automatic compare_err();
    if (err_pulse) begin
      if (exp_err_code.size() == 0) begin
        check("err_pulse_unexpected", 32'(err_pulse), 32'd0);
      end else begin
        check("err_pulse_cycle", 32'(cyc), 32'(exp_err_cyc[0]));
        check("err_code", 32'(err_code), 32'(exp_err_code[0]));
        last_err = exp_err_code.pop_front();
        void'(exp_err_cyc.pop_front());
      end
    end else begin
      if (exp_err_code.size() != 0 && exp_err_cyc[0] < cyc) begin
        check("err_pulse_missing", 32'(err_pulse), 32'd1);
        last_err = exp_err_code.pop_front();
        void'(exp_err_cyc.pop_front());
      end
      check("err_code_hold", 32'(err_code), 32'(last_err));
    end
  endtask

  // model update and output comparison, once per cycle on the falling edge
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_req_fields", {7'd0, req_write, req_addr}, 32'd0);
        check("rst_wdata_txdata", {8'd0, req_wdata, tx_data}, 32'd0);
      end else begin
        busy_now = model_busy();
        if (rx_valid) begin
          if (busy_now) push_err(2'd3);
          else model_rx(rx_data);
        end else if (pkt.size() != 0 && (cyc - last_rx_cyc) == T) begin
          push_err(2'd2);
          exp_tx.push_back(8'h45);
          pkt.delete();
        end
        if (rd_valid && waiting_rd) begin
          exp_tx.push_back(rd_data[15:8]);
          exp_tx.push_back(rd_data[7:0]);
          waiting_rd = 1'b0;
        end
        compare_req();
        compare_tx();
        compare_err();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (model_busy() && k < 300) begin
      tick(1);
      k++;
    end
    check(name, 32'(model_busy()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    req_ready = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = 16'h0000;
    tx_ready  = 1'b0;
    tick(3);
    rst = 1'b0;

    // write, ready tied high
    req_ready = 1'b1;
    tx_ready  = 1'b1;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'hBE); send_byte(8'hEF);
    wait_idle("idle_write");
    check("lit_write_addr", 32'(log_addr), 32'h001234);
    check("lit_write_data", 32'(log_wdata), 32'hBEEF);
    check("lit_write_flag", 32'(log_write), 32'd1);
    check("lit_write_ack", 32'(tx_back(0)), 32'h4B);

    // read with request and transmit back-pressure
    req_ready = 1'b0;
    tx_ready  = 1'b0;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    tick(5);
    req_ready = 1'b1;
    tick(1);
    req_ready = 1'b0;
    tick(2);
    rd_valid = 1'b1;
    rd_data  = 16'hA55A;
    tick(1);
    rd_valid = 1'b0;
    tick(4);
    tx_ready = 1'b1;
    wait_idle("idle_read");
    check("lit_read_addr", 32'(log_addr), 32'h000010);
    check("lit_read_flag", 32'(log_write), 32'd0);
    check("lit_read_hi", 32'(tx_back(1)), 32'hA5);
    check("lit_read_lo", 32'(tx_back(0)), 32'h5A);

    // bad opcode, then a normal write
    req_ready = 1'b1;
    send_byte(8'h41);
    wait_idle("idle_badop");
    check("lit_badop_code", 32'(err_code), 32'd1);
    check("lit_badop_tx", 32'(tx_back(0)), 32'h45);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    wait_idle("idle_after_badop");
    check("lit_after_badop_addr", 32'(log_addr), 32'h000001);
    check("lit_after_badop_data", 32'(log_wdata), 32'h1234);
    check("lit_after_badop_ack", 32'(tx_back(0)), 32'h4B);

    // inter-byte timeout
    send_byte(8'h57); send_byte(8'h00);
    tick(T + 5);
    wait_idle("idle_timeout");
    check("lit_timeout_code", 32'(err_code), 32'd2);
    check("lit_timeout_tx", 32'(tx_back(0)), 32'h45);

    // byte landing in the expiry cycle keeps the packet alive
    send_byte(8'h57); send_byte(8'h00);
    tick(T - 1);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD);
    wait_idle("idle_near_timeout");
    check("lit_near_addr", 32'(log_addr), 32'h000002);
    check("lit_near_data", 32'(log_wdata), 32'hABCD);
    check("lit_near_code_kept", 32'(err_code), 32'd2);

    // overrun while waiting for read data
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    tick(1);
    send_byte(8'h52);
    rd_valid = 1'b1;
    rd_data  = 16'h1357;
    tick(1);
    rd_valid = 1'b0;
    wait_idle("idle_overrun");
    check("lit_overrun_code", 32'(err_code), 32'd3);
    check("lit_overrun_hi", 32'(tx_back(1)), 32'h13);
    check("lit_overrun_lo", 32'(tx_back(0)), 32'h57);
    check("lit_overrun_addr", 32'(log_addr), 32'h000020);

    // reset while a request is pending
    req_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h30);
    tick(1);
    check("lit_pre_rst_req_valid", 32'(req_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("lit_async_req_valid", 32'(req_valid), 32'd0);
    check("lit_async_tx_valid", 32'(tx_valid), 32'd0);
    tick(2);
    rst = 1'b0;
    check("lit_post_rst_code", 32'(err_code), 32'd0);
    req_ready = 1'b1;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    tick(1);
    rd_valid = 1'b1;
    rd_data  = 16'hC33C;
    tick(1);
    rd_valid = 1'b0;
    wait_idle("idle_post_rst");
    check("lit_post_rst_addr", 32'(log_addr), 32'h000040);
    check("lit_post_rst_hi", 32'(tx_back(1)), 32'hC3);
    check("lit_post_rst_lo", 32'(tx_back(0)), 32'h3C);

    tick(3);
    check("end_exp_err_empty", 32'(exp_err_code.size()), 32'd0);
    check("end_exp_tx_empty", 32'(exp_tx.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
